// File: rtl/load_store_unit.sv
// Load/store unit: sub-word and split accesses over a word-wide memory port using read-modify-write.
// Optional feature macro MISALIGN_SPLIT_EN: when defined, word-crossing accesses become two word accesses; otherwise they are errors.
module load_store_unit (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [31:0] daddr_o,
    output logic [31:0] dwdata_o,
    input  logic [31:0] drdata_i,
    output logic [1:0]  dsize_o,
    output logic        drd_o,
    output logic        dwr_o,
    output logic [3:0]  dbe_o
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_WR0  = 3'd3,
        ST_WR1  = 3'd4,
        ST_RESP = 3'd5
    } state_t;

    state_t      state_r, state_nx_s;
    logic        we_r, uns_r, err_r, span2_r;
    logic [31:0] addr_r, wdata_r, buf0_r, buf1_r;
    logic [1:0]  size_r;

    logic        req_err_s, req_span2_s;
    logic [29:0] word1_s;
    logic [63:0] pair_s, mask64_s, wide_s, merged_s;
    logic [5:0]  shamt_s;
    logic [7:0]  lane_s, lane_sh_s;
    logic [31:0] load_sh_s, load_s;

    // Classify the incoming request: illegal size, word-crossing split or misalignment error.
    always_comb begin
        req_span2_s = 1'b0;
        req_err_s   = (req_size_i == 2'b11);
`ifdef MISALIGN_SPLIT_EN
        case (req_size_i)
            SIZE_HALF: req_span2_s = (req_addr_i[1:0] == 2'b11);
            SIZE_WORD: req_span2_s = (req_addr_i[1:0] != 2'b00);
            default:   req_span2_s = 1'b0;
        endcase
`else
        case (req_size_i)
            SIZE_HALF: req_err_s = req_addr_i[0];
            SIZE_WORD: req_err_s = (req_addr_i[1:0] != 2'b00);
            default:   req_err_s = (req_size_i == 2'b11);
        endcase
`endif
    end

    // Next-state logic; request inputs only matter in IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!req_valid_i) begin
                    state_nx_s = ST_IDLE;
                end else if (req_err_s) begin
                    state_nx_s = ST_RESP;
                end else if (req_we_i && (req_size_i == SIZE_WORD) && (req_addr_i[1:0] == 2'b00)) begin
                    state_nx_s = ST_WR0;
                end else begin
                    state_nx_s = ST_RD0;
                end
            end
            ST_RD0: begin
                if (span2_r) begin
                    state_nx_s = ST_RD1;
                end else if (we_r) begin
                    state_nx_s = ST_WR0;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            ST_RD1: begin
                if (we_r) begin
                    state_nx_s = ST_WR0;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            ST_WR0: begin
                if (span2_r) begin
                    state_nx_s = ST_WR1;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            ST_WR1:  state_nx_s = ST_RESP;
            ST_RESP: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Byte-lane merge for stores and extraction/extension for loads over the two-word buffer.
    always_comb begin
        pair_s   = {buf1_r, buf0_r};
        shamt_s  = {1'b0, addr_r[1:0], 3'b000};
        mask64_s = 64'd0;
        case (size_r)
            SIZE_BYTE: lane_s = 8'h01;
            SIZE_HALF: lane_s = 8'h03;
            default:   lane_s = 8'h0F;
        endcase
        lane_sh_s = lane_s << addr_r[1:0];
        for (int i = 0; i < 8; i++) begin
            mask64_s[i*8 +: 8] = {8{lane_sh_s[i]}};
        end
        // Memory zeroes unselected lanes, so untouched bytes must be written back from the buffer.
        wide_s    = {32'd0, wdata_r} << shamt_s;
        merged_s  = (pair_s & ~mask64_s) | (wide_s & mask64_s);
        load_sh_s = 32'(pair_s >> shamt_s);
        case (size_r)
            SIZE_BYTE: load_s = {{24{~uns_r & load_sh_s[7]}}, load_sh_s[7:0]};
            SIZE_HALF: load_s = {{16{~uns_r & load_sh_s[15]}}, load_sh_s[15:0]};
            default:   load_s = load_sh_s;
        endcase
    end

    assign word1_s = addr_r[31:2] + 30'd1;

    // Moore output decode from the state and latched request.
    always_comb begin
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_err_o   = 1'b0;
        rsp_rdata_o = 32'd0;
        daddr_o     = 32'd0;
        dwdata_o    = 32'd0;
        drd_o       = 1'b0;
        dwr_o       = 1'b0;
        dsize_o     = SIZE_WORD;
        case (state_r)
            ST_IDLE: req_ready_o = 1'b1;
            ST_RD0: begin
                drd_o   = 1'b1;
                daddr_o = {2'b00, addr_r[31:2]};
            end
            ST_RD1: begin
                drd_o   = 1'b1;
                daddr_o = {2'b00, word1_s};
            end
            ST_WR0: begin
                dwr_o    = 1'b1;
                daddr_o  = {2'b00, addr_r[31:2]};
                dwdata_o = merged_s[31:0];
            end
            ST_WR1: begin
                dwr_o    = 1'b1;
                daddr_o  = {2'b00, word1_s};
                dwdata_o = merged_s[63:32];
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = err_r;
                if (err_r || we_r) begin
                    rsp_rdata_o = 32'd0;
                end else begin
                    rsp_rdata_o = load_s;
                end
            end
            default: req_ready_o = 1'b0;
        endcase
        dbe_o = dwr_o ? 4'b1111 : 4'b0000;
    end

    // State register, request latch and read buffers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= ST_IDLE;
            we_r    <= 1'b0;
            uns_r   <= 1'b0;
            err_r   <= 1'b0;
            span2_r <= 1'b0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            size_r  <= 2'b00;
            buf0_r  <= 32'd0;
            buf1_r  <= 32'd0;
        end else begin
            state_r <= state_nx_s;
            if ((state_r == ST_IDLE) && req_valid_i) begin
                we_r    <= req_we_i;
                uns_r   <= req_unsigned_i;
                err_r   <= req_err_s;
                span2_r <= req_span2_s;
                addr_r  <= req_addr_i;
                wdata_r <= req_wdata_i;
                size_r  <= req_size_i;
            end
            if (state_r == ST_RD0) begin
                buf0_r <= drdata_i;
            end
            if (state_r == ST_RD1) begin
                buf1_r <= drdata_i;
            end
        end
    end

endmodule
